// File: rtl/candy_pkg.sv
// Shared types for the candy dispense sequencer: FSM state encoding and
// DC H-bridge drive patterns.
package candy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPINUP,
        STEP,
        BACKOFF,
        DONE
    } state_t;

    typedef struct packed {
        logic in1;
        logic in2;
    } dc_drive_t;

    localparam dc_drive_t DC_STOP = '{in1: 1'b0, in2: 1'b1};
    localparam dc_drive_t DC_FWD  = '{in1: 1'b1, in2: 1'b0};

endpackage

// File: rtl/candy_pwm_gen.sv
// Free-running DC PWM generator: period counter, duty clamp and compare.
// Duty values at or above PWM_PERIOD give a constant-high output.
module candy_pwm_gen #(
    parameter int PWM_PERIOD = 100,
    parameter int DUTY_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int CMP_W = ((DUTY_W > CNT_W) ? DUTY_W : CNT_W) + 1;

    logic [CNT_W-1:0] cnt;
    logic [CMP_W-1:0] duty_ext;
    logic [CMP_W-1:0] duty_clamped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(PWM_PERIOD - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Compare is done one bit wider than either operand so the clamp value
    // PWM_PERIOD itself is representable.
    always_comb begin
        duty_ext     = CMP_W'(duty);
        duty_clamped = (duty_ext > CMP_W'(PWM_PERIOD)) ? CMP_W'(PWM_PERIOD) : duty_ext;
        pwm          = (CMP_W'(cnt) < duty_clamped);
    end

endmodule

// File: rtl/candy_dispense_seq.sv
// Candy dispense sequencer: DC spin-up, counted stepper run, 4-phase host
// handshake. Define CANDY_DISPENSE_BACKOFF_EN to add a reverse back-off run.
module candy_dispense_seq
    import candy_pkg::*;
#(
    parameter int STEP_DIV        = 2000,
    parameter int STEPS_PER_UNIT  = 64,
    parameter int SPINUP_CYC      = 20000,
    parameter int PWM_PERIOD      = 100,
    parameter int DUTY_W          = 7,
    parameter int BACKOFF_STEPS   = 8,
    localparam int STEP_CNT_W     = $clog2(4*STEPS_PER_UNIT+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            amount_sel,
    input  logic                  dir_sel,
    input  logic [DUTY_W-1:0]     dc_duty,
    output logic                  step_o,
    output logic                  dir_o,
    output logic                  dc_in1,
    output logic                  dc_in2,
    output logic                  dc_pwm,
    output logic                  busy,
    output logic                  done_o,
    output logic                  aborted_o,
    output logic [STEP_CNT_W-1:0] steps_left
);

    localparam int PH_MAX = (SPINUP_CYC > STEP_DIV) ? SPINUP_CYC : STEP_DIV;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_t            state;
    logic              start_m, start_s;
    logic              abort_m, abort_s;
    logic              dir_l;
    logic [DUTY_W-1:0] duty_l;
    logic [PH_W-1:0]   phase_cnt;
    logic              pwm_raw;
    logic              active;
    logic              spin_tick;
    logic              step_tick;

`ifdef CANDY_DISPENSE_BACKOFF_EN
    localparam int BO_W = $clog2(BACKOFF_STEPS + 1);
    logic [BO_W-1:0]   bo_left;
`endif

    candy_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_W     (DUTY_W)
    ) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .duty (duty_l),
        .pwm  (pwm_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_m <= 1'b0;
            start_s <= 1'b0;
            abort_m <= 1'b0;
            abort_s <= 1'b0;
        end else begin
            start_m <= start;
            start_s <= start_m;
            abort_m <= abort;
            abort_s <= abort_m;
        end
    end

    assign active    = (state == SPINUP) || (state == STEP) || (state == BACKOFF);
    assign spin_tick = (phase_cnt == PH_W'(SPINUP_CYC - 1));
    assign step_tick = (phase_cnt == PH_W'(STEP_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            step_o           <= 1'b0;
            dir_o            <= 1'b0;
            {dc_in1, dc_in2} <= DC_STOP;
            dc_pwm           <= 1'b0;
            busy             <= 1'b0;
            done_o           <= 1'b0;
            aborted_o        <= 1'b0;
            steps_left       <= '0;
            dir_l            <= 1'b0;
            duty_l           <= '0;
            phase_cnt        <= '0;
`ifdef CANDY_DISPENSE_BACKOFF_EN
            bo_left          <= '0;
`endif
        end else if (active && abort_s) begin
            // Abort wins over withdrawal and freezes steps_left for the host.
            step_o           <= 1'b0;
            {dc_in1, dc_in2} <= DC_STOP;
            dc_pwm           <= 1'b0;
            busy             <= 1'b0;
            done_o           <= 1'b1;
            aborted_o        <= 1'b1;
            state            <= DONE;
        end else if (active && !start_s) begin
            step_o           <= 1'b0;
            {dc_in1, dc_in2} <= DC_STOP;
            dc_pwm           <= 1'b0;
            busy             <= 1'b0;
            state            <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    step_o           <= 1'b0;
                    {dc_in1, dc_in2} <= DC_STOP;
                    dc_pwm           <= 1'b0;
                    busy             <= 1'b0;
                    if (start_s) begin
                        steps_left       <= STEP_CNT_W'((32'(amount_sel) + 32'd1) * STEPS_PER_UNIT);
                        dir_l            <= dir_sel;
                        duty_l           <= dc_duty;
                        phase_cnt        <= '0;
                        {dc_in1, dc_in2} <= DC_FWD;
                        busy             <= 1'b1;
                        state            <= SPINUP;
                    end
                end

                SPINUP: begin
                    dc_pwm <= pwm_raw;
                    if (spin_tick) begin
                        phase_cnt <= '0;
                        step_o    <= 1'b0;
                        dir_o     <= dir_l;
                        state     <= STEP;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                STEP: begin
                    dc_pwm <= pwm_raw;
                    if (step_tick) begin
                        phase_cnt <= '0;
                        if (!step_o) begin
                            step_o <= 1'b1;
                        end else if (steps_left == STEP_CNT_W'(1)) begin
                            step_o           <= 1'b0;
                            steps_left       <= '0;
                            {dc_in1, dc_in2} <= DC_STOP;
                            dc_pwm           <= 1'b0;
`ifdef CANDY_DISPENSE_BACKOFF_EN
                            bo_left          <= BO_W'(BACKOFF_STEPS);
                            dir_o            <= ~dir_l;
                            state            <= BACKOFF;
`else
                            busy             <= 1'b0;
                            done_o           <= 1'b1;
                            state            <= DONE;
`endif
                        end else begin
                            step_o     <= 1'b0;
                            steps_left <= steps_left - 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

`ifdef CANDY_DISPENSE_BACKOFF_EN
                // Reverse run with the DC motor off; counted apart from steps_left.
                BACKOFF: begin
                    if (step_tick) begin
                        phase_cnt <= '0;
                        if (!step_o) begin
                            step_o <= 1'b1;
                        end else if (bo_left <= BO_W'(1)) begin
                            step_o  <= 1'b0;
                            bo_left <= '0;
                            busy    <= 1'b0;
                            done_o  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            step_o  <= 1'b0;
                            bo_left <= bo_left - 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
`endif

                DONE: begin
                    step_o           <= 1'b0;
                    {dc_in1, dc_in2} <= DC_STOP;
                    dc_pwm           <= 1'b0;
                    busy             <= 1'b0;
                    if (!start_s) begin
                        done_o    <= 1'b0;
                        aborted_o <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_candy_dispense_seq.sv
// Self-checking bench for candy_dispense_seq: table vectors, random runs
// against a transaction-level model, and hand-written reset/abort/withdraw cases.
module tb_candy_dispense_seq;

    localparam int STEP_DIV   = 4;
    localparam int SPU        = 4;
    localparam int SPINUP     = 10;
    localparam int PERIOD     = 10;
    localparam int DUTY_W     = 7;
    localparam int BO_STEPS   = 2;
    localparam int SL_W       = $clog2(4*SPU+1);
    localparam int LIMIT      = 3000;
`ifdef CANDY_DISPENSE_BACKOFF_EN
    localparam int EXP_REV    = BO_STEPS;
`else
    localparam int EXP_REV    = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [1:0]        amount_sel;
    logic              dir_sel;
    logic [DUTY_W-1:0] dc_duty;
    logic              step_o, dir_o, dc_in1, dc_in2, dc_pwm, busy, done_o, aborted_o;
    logic [SL_W-1:0]   steps_left;

    int checks   = 0;
    int failures = 0;

    candy_dispense_seq #(
        .STEP_DIV       (STEP_DIV),
        .STEPS_PER_UNIT (SPU),
        .SPINUP_CYC     (SPINUP),
        .PWM_PERIOD     (PERIOD),
        .DUTY_W         (DUTY_W),
        .BACKOFF_STEPS  (BO_STEPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .amount_sel (amount_sel),
        .dir_sel    (dir_sel),
        .dc_duty    (dc_duty),
        .step_o     (step_o),
        .dir_o      (dir_o),
        .dc_in1     (dc_in1),
        .dc_in2     (dc_in2),
        .dc_pwm     (dc_pwm),
        .busy       (busy),
        .done_o     (done_o),
        .aborted_o  (aborted_o),
        .steps_left (steps_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        int amount;
        int dir;
        int duty;
        int abort_after;
        int exp_pulses;
        int exp_in1;
        int exp_pwm;
        int exp_left;
        int exp_aborted;
    } vec_t;

    vec_t tbl[5];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Transaction-level model: what one dispense cycle should look like.
    function automatic vec_t modelVec(input int amount, input int dir, input int duty,
                                      input int abort_after);
        vec_t v;
        int   total;
        total         = (amount + 1) * SPU;
        v.amount      = amount;
        v.dir         = dir;
        v.duty        = duty;
        v.abort_after = abort_after;
        v.exp_pulses  = (abort_after > 0) ? abort_after : total;
        v.exp_in1     = (abort_after > 0) ? -1 : SPINUP + total * 2 * STEP_DIV;
        v.exp_pwm     = (duty > PERIOD) ? PERIOD : duty;
        v.exp_left    = (abort_after > 0) ? total - abort_after : 0;
        v.exp_aborted = (abort_after > 0) ? 1 : 0;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        int lat, idx, total, falls, want;
        int in1_cyc, pwm_hi, fwd, rev, first_rise, last_rise;
        int period_bad, left_bad, early_done, retrig;
        logic prev_step;
        total      = (v.amount + 1) * SPU;
        falls      = 0;
        in1_cyc    = 0;
        pwm_hi     = 0;
        fwd        = 0;
        rev        = 0;
        first_rise = -1;
        last_rise  = -1;
        period_bad = 0;
        left_bad   = 0;
        early_done = 0;
        retrig     = 0;
        prev_step  = 1'b0;

        @(negedge clk);
        amount_sel = 2'(v.amount);
        dir_sel    = v.dir[0];
        dc_duty    = DUTY_W'(v.duty);
        start      = 1'b1;
        lat = 0;
        while (!busy && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("busy_latency_ok", (lat >= 2 && lat <= 3) ? 1 : 0, 1);

        idx = 0;
        while (busy && idx < LIMIT) begin
            if (dc_in1) in1_cyc++;
            if (idx >= 1 && idx <= PERIOD && dc_pwm) pwm_hi++;
            if (done_o) early_done++;
            if (step_o && !prev_step) begin
                if (first_rise < 0) first_rise = idx;
                else if (idx - last_rise != 2 * STEP_DIV) period_bad++;
                last_rise = idx;
                if (dir_o == v.dir[0]) fwd++;
                else rev++;
            end
            if (!step_o && prev_step) falls++;
            want = (falls >= total) ? 0 : total - falls;
            if (int'(steps_left) != want) left_bad++;
            prev_step = step_o;
            if (v.abort_after > 0 && falls == v.abort_after) abort = 1'b1;
            @(negedge clk);
            idx++;
        end
        abort = 1'b0;

        checkOutput("run_in_time", (idx < LIMIT) ? 1 : 0, 1);
        checkOutput("fwd_pulses", fwd, v.exp_pulses);
        checkOutput("rev_pulses", rev, v.exp_aborted ? 0 : EXP_REV);
        checkOutput("first_step_idx", first_rise, SPINUP + STEP_DIV);
        checkOutput("step_period_errs", period_bad, 0);
        checkOutput("steps_left_trace_errs", left_bad, 0);
        checkOutput("pwm_high_per_period", pwm_hi, v.exp_pwm);
        checkOutput("done_while_busy", early_done, 0);
        if (v.exp_in1 >= 0) checkOutput("dc_fwd_cycles", in1_cyc, v.exp_in1);
        checkOutput("done_o", done_o, 1);
        checkOutput("aborted_o", aborted_o, v.exp_aborted);
        checkOutput("steps_left_end", int'(steps_left), v.exp_left);
        checkOutput("motors_stopped", int'({step_o, dc_in1, dc_in2, dc_pwm, busy}), 4);

        // start still high in DONE must not launch another cycle
        repeat (12) begin
            @(negedge clk);
            if (busy || !done_o) retrig++;
        end
        checkOutput("no_retrigger", retrig, 0);

        start = 1'b0;
        lat = 0;
        while (done_o && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("done_release_ok", (!done_o && lat <= 3) ? 1 : 0, 1);
        checkOutput("aborted_clear", aborted_o, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int lat, seen_done;
        vec_t rv;

        tbl[0] = '{0, 1,   5, 0,  4,  42,  5, 0, 0};
        tbl[1] = '{3, 0,   0, 0, 16, 138,  0, 0, 0};
        tbl[2] = '{2, 1, 127, 0, 12, 106, 10, 0, 0};
        tbl[3] = '{1, 0,  10, 0,  8,  74, 10, 0, 0};
        tbl[4] = '{1, 1,   3, 2,  2,  -1,  3, 6, 1};

        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        amount_sel = '0;
        dir_sel    = 1'b0;
        dc_duty    = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    int'({step_o, dir_o, dc_in1, dc_in2, dc_pwm, busy, done_o, aborted_o}), 16);
        checkOutput("reset_steps_left", int'(steps_left), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] table vectors");
        for (int i = 0; i < 5; i++) applyStimulus(tbl[i]);

        $display("[TB] random runs");
        for (int r = 0; r < 6; r++) begin
            int a, d, du, ab;
            a  = $urandom_range(0, 3);
            d  = $urandom_range(0, 1);
            du = $urandom_range(0, 127);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (a + 1) * SPU - 1) : 0;
            rv = modelVec(a, d, du, ab);
            applyStimulus(rv);
        end

        $display("[TB] withdrawal during spin-up");
        @(negedge clk);
        amount_sel = 2'd0;
        dir_sel    = 1'b0;
        dc_duty    = 7'd4;
        start      = 1'b1;
        lat = 0;
        while (!busy && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        repeat (4) @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (busy && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("withdraw_idle", busy, 0);
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_o) seen_done++;
        end
        checkOutput("withdraw_no_done", seen_done, 0);
        checkOutput("withdraw_dc_stop", int'({dc_in1, dc_in2, dc_pwm}), 2);
        applyStimulus(tbl[0]);

        $display("[TB] reset mid-step");
        @(negedge clk);
        amount_sel = 2'd1;
        dir_sel    = 1'b1;
        dc_duty    = 7'd5;
        start      = 1'b1;
        lat = 0;
        while (!step_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("reached_step", step_o, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs",
                    int'({step_o, dir_o, dc_in1, dc_in2, dc_pwm, busy, done_o, aborted_o}), 16);
        checkOutput("async_reset_steps_left", int'(steps_left), 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || done_o) seen_done++;
        end
        checkOutput("idle_after_reset", seen_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/candy_dispense_seq.md
Name: candy_dispense_seq

Overview:
Parametrised successor to the board-level dispense controller. It runs one complete dispense cycle per host request: DC agitator spin-up, a counted number of stepper steps, then a level handshake back to the Raspberry Pi. It replaces divided-clock motor drive with clock enables and programmable PWM duty. It sits between the host GPIO inputs and the stepper and DC driver pins.

Parameters:
STEP_DIV, 2000, clk cycles per step_o half-period (one step = 2*STEP_DIV cycles)
STEPS_PER_UNIT, 64, steps per amount unit; total steps = (amount_sel+1)*STEPS_PER_UNIT
SPINUP_CYC, 20000, clk cycles of DC drive before stepping begins
PWM_PERIOD, 100, clk cycles per DC PWM period
DUTY_W, 7, width of dc_duty
BACKOFF_STEPS, 8, reverse steps after dispense (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  host dispense request (candyflag), level, asynchronous
abort  in  1  host abort, level, asynchronous
amount_sel  in  2  amount code 0..3
dir_sel  in  1  stepper direction for the dispense
dc_duty  in  DUTY_W  DC PWM high count per period
step_o  out  1  stepper step
dir_o  out  1  stepper direction
dc_in1  out  1  DC H-bridge input 1
dc_in2  out  1  DC H-bridge input 2
dc_pwm  out  1  DC enable / PWM
busy  out  1  high in SPINUP, STEP, BACKOFF
done_o  out  1  handshake to host
aborted_o  out  1  qualifies done_o; high when the cycle ended by abort
steps_left  out  STEP_CNT_W  remaining steps; STEP_CNT_W = $clog2(4*STEPS_PER_UNIT+1)

Behaviour:
- start and abort each pass through a 2-FF synchroniser (start_s, abort_s). FSM reacts 2 cycles after the input edge.
- Reset values: step_o=0, dir_o=0, dc_in1=0, dc_in2=1, dc_pwm=0, busy=0, done_o=0, aborted_o=0, steps_left=0. The state register resets to IDLE and all counters reset to 0.
- IDLE:
  - Motors stopped: in1=0, in2=1, pwm=0, step_o=0.
  - When start_s=1: latch amount_sel, dir_sel and dc_duty; load steps_left=(amount_sel+1)*STEPS_PER_UNIT; go to SPINUP.
- SPINUP:
  - in1=1, in2=0, dc_pwm driven by PWM.
  - After exactly SPINUP_CYC cycles, go to STEP with the step phase counter cleared.
- STEP:
  - DC continues as in SPINUP. dir_o = latched dir.
  - step_o toggles every STEP_DIV cycles, starting low.
  - Each high-to-low transition decrements steps_left.
  - When steps_left reaches 0: go to DONE, or to BACKOFF if the optional feature is compiled in. step_o is low on exit.
- DONE:
  - Motors stopped as in IDLE. done_o=1.
  - When start_s=0: go to IDLE; done_o and aborted_o clear on that same transition.
  - Handshake is 4-phase. Start held high in DONE never retriggers.
- Abort: abort_s=1 in SPINUP, STEP or BACKOFF goes to DONE next cycle with aborted_o=1 and steps_left frozen. abort_s in IDLE or DONE is ignored.
- Host withdrawal: start_s=0 in SPINUP, STEP or BACKOFF goes straight to IDLE with motors stopped and done_o never asserted.
- Priority: abort over withdrawal.
- PWM:
  - Free-running counter 0..PWM_PERIOD-1.
  - dc_pwm = (cnt < duty_l), with duty_l clamped to PWM_PERIOD.
  - duty 0 gives constant low; duty >= PWM_PERIOD gives constant high.
  - Inputs changed mid-cycle have no effect until the next IDLE latch.

Optional Feature:
- Macro: CANDY_DISPENSE_BACKOFF_EN.
- Defined: the STEP exit goes to BACKOFF.
  - DC stopped (in1=0, in2=1, pwm=0). dir_o is the inverted latched dir.
  - BACKOFF_STEPS steps run at the same rate, counted internally; steps_left stays 0.
  - Then go to DONE. Abort and withdrawal apply as above.
- Undefined: no BACKOFF state exists; STEP goes directly to DONE.

Decomposition:
- Package candy_pkg:
  - state enum (IDLE, SPINUP, STEP, BACKOFF, DONE).
  - DC drive constants: stop = {in1 0, in2 1}, fwd = {1, 0}.
- One sub-module, candy_pwm_gen, holding the period counter, duty clamp and compare. Parameters PWM_PERIOD and DUTY_W.
- Synchronisers and FSM stay in the top module.

Test Plan (STEP_DIV=4, STEPS_PER_UNIT=4, SPINUP_CYC=10, PWM_PERIOD=10):
1. Reset asserted mid-STEP -> all outputs at reset values asynchronously; after release the block stays in IDLE with start=0.
2. start=1, amount_sel=0, dir_sel=1, duty=5 -> busy 2 cycles later, 10 cycles of in1=1 with pwm 5/10, then exactly 4 step pulses of 8-cycle period with dir_o=1; done_o=1, steps_left=0. Then start=0 -> done_o=0 by 2 cycles.
3. amount_sel=3 -> 16 step pulses; steps_left counts 16..0. duty=0 gives pwm constant low; duty=127 gives pwm constant high.
4. abort pulse after step 2 of amount_sel=1 -> DONE with aborted_o=1, steps_left=6, motors stopped. A second start during DONE does not retrigger.
5. start dropped during SPINUP -> IDLE, done_o never asserted. Next start runs a full cycle.
6. With CANDY_DISPENSE_BACKOFF_EN and BACKOFF_STEPS=2: after 4 forward steps, DC off, dir_o inverts, 2 steps run, then done_o=1.
